romload_stream: RTL and testbench

ROMLOAD_STREAM -- requirements
Module: romload_stream

---
 rtl/romload_stream.sv | 165 ++++++++++++++++
 tb/tb_romload_stream.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/romload_stream.sv
// CPU-fed ROM loader: captures HDR_WORDS header words, then queues DW-bit words in a
// small FIFO and serializes them into OW-bit slices on a valid/ready stream.
module romload_stream #(
  parameter int DW        = 32,
  parameter int OW        = 8,
  parameter int DEPTH     = 4,
  parameter int HDR_WORDS = 3,
  parameter int MSB_FIRST = 0,
  localparam int HW       = (HDR_WORDS > 0) ? HDR_WORDS * DW : 1
) (
  input  logic          wclk,
  input  logic          reset,
  input  logic          reg_ctrl_we,
  input  logic          reg_data_we,
  input  logic [DW-1:0] reg_wdata,
  output logic          reg_wait,
  output logic          rom_loading,
  output logic [HW-1:0] hdr,
  output logic          hdr_valid,
  output logic [OW-1:0] rom_do,
  output logic          rom_do_valid,
  input  logic          rom_do_ready,
  output logic [23:0]   rom_count
);

  localparam int R   = DW / OW;
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int SW  = (R > 1) ? $clog2(R) : 1;
  localparam int HIW = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, HEADER = 2'd1, DATA = 2'd2, DRAIN = 2'd3} state_t;

  state_t state, state_nxt;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] word;
  logic [SW-1:0] sl, sel;
  logic          ser_valid;

  logic do_start, do_finish, do_abort, data_wr, flush;
  logic empty, full, xfer, last, ser_free;
  logic push_req, push, pop, bypass, ser_load, drained, hdr_last;

  // A control write in the same cycle wins over a data write.
  assign do_start  = reg_ctrl_we && (reg_wdata[7:0] == 8'd1);
  assign do_finish = reg_ctrl_we && (reg_wdata[7:0] == 8'd0);
  assign do_abort  = reg_ctrl_we && (reg_wdata[7:0] == 8'd2);
  assign data_wr   = reg_data_we && !reg_ctrl_we;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign xfer     = ser_valid && rom_do_ready;
  assign last     = (sl == SW'(R - 1));
  assign ser_free = !ser_valid || (xfer && last);

  // Full is registered, so a stalled write lands one cycle after the freeing pop.
  assign push_req = (state == DATA) && data_wr;
  assign reg_wait = push_req && full;
  assign bypass   = push_req && ser_free && empty;
  assign push     = push_req && !full && !bypass;
  assign pop      = ser_free && !empty;
  assign ser_load = pop || bypass;
  assign drained  = empty && ser_free;

  assign sel          = (MSB_FIRST != 0) ? SW'(R - 1) - sl : sl;
  assign rom_do       = word[sel*OW +: OW];
  assign rom_do_valid = ser_valid;
  assign rom_loading  = (state != IDLE);

  always_ff @(posedge wclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // An already-empty FINISH skips the DRAIN cycle so it completes in one cycle.
  always_comb begin
    state_nxt = state;
    flush     = 1'b0;
    if (do_start) begin
      flush     = 1'b1;
      state_nxt = (HDR_WORDS == 0) ? DATA : HEADER;
    end else if (do_abort) begin
      flush     = 1'b1;
      state_nxt = IDLE;
    end else if (do_finish && (state == HEADER || state == DATA)) begin
      state_nxt = drained ? IDLE : DRAIN;
    end else begin
      case (state)
        HEADER:  if (data_wr && hdr_last) state_nxt = DATA;
        DRAIN:   if (drained) state_nxt = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge wclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= reg_wdata;
  end

  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      word      <= '0;
      sl        <= '0;
      ser_valid <= 1'b0;
      rom_count <= '0;
      hdr_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      word      <= '0;
      sl        <= '0;
      ser_valid <= 1'b0;
      if (do_start) begin
        rom_count <= '0;
        hdr_valid <= (HDR_WORDS == 0);
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (xfer) rom_count <= rom_count + 24'd1;
      // Reload on the last accepted slice keeps the stream gap-free.
      if (ser_load) begin
        word      <= pop ? mem[rd_ptr[AW-1:0]] : reg_wdata;
        sl        <= '0;
        ser_valid <= 1'b1;
      end else if (xfer) begin
        if (last) ser_valid <= 1'b0;
        else      sl <= sl + SW'(1);
      end
      if (state == HEADER && data_wr && hdr_last) hdr_valid <= 1'b1;
    end
  end

  generate
    if (HDR_WORDS > 0) begin : g_hdr
      logic [HIW-1:0] hdr_idx;
      logic [HW-1:0]  hdr_q;

      always_ff @(posedge wclk or posedge reset) begin
        if (reset) begin
          hdr_idx <= '0;
          hdr_q   <= '0;
        end else if (do_start) begin
          hdr_idx <= '0;
          hdr_q   <= '0;
        end else if (state == HEADER && data_wr) begin
          hdr_q[hdr_idx*DW +: DW] <= reg_wdata;
          hdr_idx                 <= hdr_idx + HIW'(1);
        end
      end

      assign hdr      = hdr_q;
      assign hdr_last = (hdr_idx == HIW'(HDR_WORDS - 1));
    end else begin : g_nohdr
      assign hdr      = '0;
      assign hdr_last = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_romload_stream.sv
// Bench for romload_stream: default-parameter instance plus an MSB-first 16-bit instance,
// checked against a slice-queue model derived from the word/slice ordering rules.
module tb_romload_stream;

  logic wclk, rst;

  logic        ctrl_we, data_we, ready;
  logic [31:0] wdata;
  logic        reg_wait, loading, hdr_valid, rvalid;
  logic [95:0] hdr;
  logic [7:0]  rdo;
  logic [23:0] count;

  logic        m_ctrl_we, m_data_we, m_ready;
  logic [31:0] m_wdata;
  logic        m_wait, m_loading, m_hdr_valid, m_valid;
  logic [0:0]  m_hdr;
  logic [15:0] m_do;
  logic [23:0] m_count;

  int checks = 0, errors = 0, cyc_n = 0;
  logic [15:0] rx_q[$], m_rx_q[$], exp_q[$];
  int          rx_cyc[$];
  logic [95:0] hdr_model;

  romload_stream u_dut (
    .wclk(wclk), .reset(rst), .reg_ctrl_we(ctrl_we), .reg_data_we(data_we),
    .reg_wdata(wdata), .reg_wait(reg_wait), .rom_loading(loading), .hdr(hdr),
    .hdr_valid(hdr_valid), .rom_do(rdo), .rom_do_valid(rvalid),
    .rom_do_ready(ready), .rom_count(count)
  );

  romload_stream #(.DW(32), .OW(16), .DEPTH(4), .HDR_WORDS(0), .MSB_FIRST(1)) u_msb (
    .wclk(wclk), .reset(rst), .reg_ctrl_we(m_ctrl_we), .reg_data_we(m_data_we),
    .reg_wdata(m_wdata), .reg_wait(m_wait), .rom_loading(m_loading), .hdr(m_hdr),
    .hdr_valid(m_hdr_valid), .rom_do(m_do), .rom_do_valid(m_valid),
    .rom_do_ready(m_ready), .rom_count(m_count)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  always @(posedge wclk) cyc_n++;

  always @(negedge wclk) begin
    if (rvalid && ready && !rst) begin
      rx_q.push_back({8'h00, rdo});
      rx_cyc.push_back(cyc_n);
    end
    if (m_valid && m_ready && !rst) m_rx_q.push_back(m_do);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Reference model: a word leaves as DW/OW slices, lowest first unless msb is set.
  function automatic void push_exp(input logic [31:0] w, input int ow, input bit msb);
    int r;
    int k;
    r = 32 / ow;
    for (int i = 0; i < r; i++) begin
      k = msb ? (r - 1 - i) : i;
      exp_q.push_back(16'((w >> (k * ow)) & ((32'h1 << ow) - 32'h1)));
    end
  endfunction

  task automatic cyc();
    @(posedge wclk); #1;
  endtask

  task automatic ctrl(input logic [7:0] c);
    wdata   = {24'h0, c};
    ctrl_we = 1'b1;
    cyc();
    ctrl_we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d, output int stalls);
    stalls  = 0;
    data_we = 1'b1;
    wdata   = d;
    @(negedge wclk);
    while (reg_wait && stalls < 500) begin
      stalls++;
      @(negedge wclk);
    end
    if (stalls >= 500) begin
      checks++; errors++;
      $display("FAIL wr_timeout: reg_wait still %0b after %0d cycles, required 0", reg_wait, stalls);
    end
    @(posedge wclk); #1;
    data_we = 1'b0;
  endtask

  task automatic write_hdr(output int stalls);
    logic [31:0] w;
    int s;
    stalls    = 0;
    hdr_model = '0;
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      hdr_model[i*32 +: 32] = w;
      wr(w, s);
      stalls += s;
    end
  endtask

  task automatic wait_rx(input int n);
    int k;
    k = 0;
    while (rx_q.size() < n && k < 200) begin cyc(); k++; end
    if (rx_q.size() < n) begin
      checks++; errors++;
      $display("FAIL rx_timeout: got %0d slices, required %0d", rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ctrl_we = 0; data_we = 0; wdata = 0; ready = 0;
    m_ctrl_we = 0; m_data_we = 0; m_wdata = 0; m_ready = 0;
    repeat (2) cyc();
    if (loading !== 1'b0) begin errors++; $display("FAIL reset_loading: got %b required 0", loading); end
    checks++;
    if (rvalid !== 1'b0 || rdo !== 8'h00) begin errors++; $display("FAIL reset_do: got v=%b d=%h required 0/00", rvalid, rdo); end
    checks++;
    if (hdr !== 96'h0 || hdr_valid !== 1'b0) begin errors++; $display("FAIL reset_hdr: got %h/%b required 0/0", hdr, hdr_valid); end
    checks++;
    if (count !== 24'h0 || reg_wait !== 1'b0) begin errors++; $display("FAIL reset_count_wait: got %h/%b required 0/0", count, reg_wait); end
    checks++;
    rst = 1'b0;
    repeat (2) cyc();
    if (loading !== 1'b0 || m_loading !== 1'b0) begin errors++; $display("FAIL reset_release_idle: got %b/%b required 0/0", loading, m_loading); end
    checks++;
  endtask

  task automatic test_basic();
    int s, st;
    ready = 1'b1;
    ctrl(8'd1);
    if (loading !== 1'b1 || hdr_valid !== 1'b0) begin errors++; $display("FAIL start_state: got loading=%b hdr_valid=%b required 1/0", loading, hdr_valid); end
    checks++;
    st = 0;
    wr(32'h00000321, s); st += s;
    wr(32'h00FFFFFF, s); st += s;
    wr(32'h00001FFF, s); st += s;
    if (st !== 0) begin errors++; $display("FAIL hdr_no_wait: got %0d stall cycles required 0", st); end
    checks++;
    if (hdr_valid !== 1'b1 || hdr !== {32'h00001FFF, 32'h00FFFFFF, 32'h00000321}) begin
      errors++; $display("FAIL hdr_capture: got %h/%b required 00001fff00ffffff00000321/1", hdr, hdr_valid);
    end
    checks++;
    rx_q.delete(); rx_cyc.delete(); exp_q.delete();
    push_exp(32'h44332211, 8, 1'b0);
    wr(32'h44332211, s);
    if (rvalid !== 1'b1) begin errors++; $display("FAIL first_valid_latency: got %b required 1", rvalid); end
    checks++;
    wait_rx(4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_slice%0d: got %h required %h", i, rx_q[i], exp_q[i]); end
      checks++;
    end
    if (rx_cyc.size() >= 4 && (rx_cyc[3] - rx_cyc[0]) !== 3) begin errors++; $display("FAIL basic_gapfree: got span %0d required 3", rx_cyc[3] - rx_cyc[0]); end
    checks++;
    if (count !== 24'd4) begin errors++; $display("FAIL basic_count: got %0d required 4", count); end
    checks++;
    ctrl(8'd0);
    if (loading !== 1'b0) begin errors++; $display("FAIL finish_empty_1cyc: got %b required 0", loading); end
    checks++;
  endtask

  task automatic test_msb();
    int k;
    m_ready = 1'b1;
    m_wdata = 32'h1; m_ctrl_we = 1'b1; cyc(); m_ctrl_we = 1'b0;
    if (m_loading !== 1'b1 || m_hdr_valid !== 1'b1) begin errors++; $display("FAIL msb_start: got %b/%b required 1/1", m_loading, m_hdr_valid); end
    checks++;
    m_rx_q.delete(); exp_q.delete();
    push_exp(32'hAABBCCDD, 16, 1'b1);
    m_wdata = 32'hAABBCCDD; m_data_we = 1'b1; cyc(); m_data_we = 1'b0;
    k = 0;
    while (m_rx_q.size() < 2 && k < 50) begin cyc(); k++; end
    if (m_rx_q.size() !== 2) begin errors++; $display("FAIL msb_slices: got %0d slices required 2", m_rx_q.size()); end
    checks++;
    for (int i = 0; i < 2 && i < m_rx_q.size(); i++) begin
      if (m_rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL msb_slice%0d: got %h required %h", i, m_rx_q[i], exp_q[i]); end
      checks++;
    end
    if (m_count !== 24'd2) begin errors++; $display("FAIL msb_count: got %0d required 2", m_count); end
    checks++;
  endtask

  task automatic test_backpressure();
    int s, st, k;
    logic [31:0] w;
    ready = 1'b1;
    ctrl(8'd1);
    write_hdr(s);
    ready = 1'b0;
    rx_q.delete(); exp_q.delete();
    st = 0;
    for (int i = 0; i < 5; i++) begin
      w = $urandom; push_exp(w, 8, 1'b0); wr(w, s); st += s;
    end
    if (st !== 0) begin errors++; $display("FAIL bp_first5_no_wait: got %0d stall cycles required 0", st); end
    checks++;
    w = $urandom; push_exp(w, 8, 1'b0);
    data_we = 1'b1; wdata = w;
    @(negedge wclk);
    if (reg_wait !== 1'b1) begin errors++; $display("FAIL bp_sixth_wait: got %b required 1", reg_wait); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      @(negedge wclk);
      if (rvalid !== 1'b1 || {8'h00, rdo} !== exp_q[0]) begin errors++; $display("FAIL bp_hold%0d: got v=%b d=%h required 1/%h", i, rvalid, rdo, exp_q[0]); end
      checks++;
    end
    @(posedge wclk); #1;
    ready = 1'b1;
    k = 0;
    @(negedge wclk);
    while (reg_wait && k < 100) begin k++; @(negedge wclk); end
    if (reg_wait !== 1'b0) begin errors++; $display("FAIL bp_release: got reg_wait=%b required 0", reg_wait); end
    checks++;
    @(posedge wclk); #1;
    data_we = 1'b0;
    wait_rx(24);
    repeat (3) cyc();
    if (rx_q.size() !== 24) begin errors++; $display("FAIL bp_total: got %0d slices required 24", rx_q.size()); end
    checks++;
    for (int i = 0; i < 24 && i < rx_q.size(); i++) begin
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_slice%0d: got %h required %h", i, rx_q[i], exp_q[i]); end
      checks++;
    end
    if (count !== 24'd24) begin errors++; $display("FAIL bp_count: got %0d required 24", count); end
    checks++;
    ctrl(8'd0);
  endtask

  task automatic test_finish_drain();
    int s, n, k;
    bit early_drop;
    logic [31:0] w;
    ready = 1'b1;
    ctrl(8'd1);
    write_hdr(s);
    ready = 1'b0;
    rx_q.delete(); exp_q.delete();
    for (int i = 0; i < 2; i++) begin w = $urandom; push_exp(w, 8, 1'b0); wr(w, s); end
    ctrl(8'd0);
    if (loading !== 1'b1) begin errors++; $display("FAIL drain_loading: got %b required 1", loading); end
    checks++;
    ready = 1'b1; n = 0; k = 0; early_drop = 1'b0;
    while (k < 100) begin
      @(negedge wclk);
      if (!loading) early_drop = 1'b1;
      if (rvalid && ready) n++;
      if (n == 8) break;
      @(posedge wclk); #1;
      ready = ~ready; k++;
    end
    if (early_drop || n !== 8) begin errors++; $display("FAIL drain_hold: got early_drop=%b transfers=%0d required 0/8", early_drop, n); end
    checks++;
    @(posedge wclk); #1;
    if (loading !== 1'b0) begin errors++; $display("FAIL drain_done: got loading=%b required 0", loading); end
    checks++;
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL drain_slice%0d: got %h required %h", i, rx_q[i], exp_q[i]); end
      checks++;
    end
    ready = 1'b1;
    wr($urandom, s);
    repeat (3) cyc();
    if (rvalid !== 1'b0 || count !== 24'd8 || hdr !== hdr_model) begin
      errors++; $display("FAIL idle_write_ignored: got v=%b cnt=%0d hdr=%h required 0/8/%h", rvalid, count, hdr, hdr_model);
    end
    checks++;
  endtask

  task automatic test_abort();
    int s;
    ready = 1'b1;
    ctrl(8'd1);
    write_hdr(s);
    ready = 1'b0;
    wr($urandom, s);
    ready = 1'b1;
    repeat (2) cyc();
    ready = 1'b0;
    ctrl(8'd2);
    if (rvalid !== 1'b0 || loading !== 1'b0) begin errors++; $display("FAIL abort_stop: got v=%b loading=%b required 0/0", rvalid, loading); end
    checks++;
    repeat (4) cyc();
    if (count !== 24'd2) begin errors++; $display("FAIL abort_count: got %0d required 2", count); end
    checks++;
    if (hdr !== hdr_model || hdr_valid !== 1'b1) begin errors++; $display("FAIL abort_hdr_kept: got %h/%b required %h/1", hdr, hdr_valid, hdr_model); end
    checks++;
  endtask

  task automatic test_reset_mid();
    int s;
    ready = 1'b1;
    ctrl(8'd1);
    write_hdr(s);
    wr($urandom, s);
    cyc();
    rst = 1'b1;
    #1;
    if (rvalid !== 1'b0 || rdo !== 8'h00 || loading !== 1'b0) begin errors++; $display("FAIL rst_mid_out: got v=%b d=%h l=%b required 0/00/0", rvalid, rdo, loading); end
    checks++;
    if (count !== 24'h0 || hdr !== 96'h0 || hdr_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_state: got cnt=%0d hdr=%h hv=%b required 0/0/0", count, hdr, hdr_valid); end
    checks++;
    cyc();
    rst = 1'b0;
    rx_q.delete();
    wr($urandom, s);
    repeat (4) cyc();
    if (rx_q.size() !== 0 || rvalid !== 1'b0 || count !== 24'h0 || hdr !== 96'h0) begin
      errors++; $display("FAIL rst_then_write_ignored: got slices=%0d v=%b cnt=%0d hdr=%h required 0/0/0/0", rx_q.size(), rvalid, count, hdr);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    int s;
    bit done;
    logic [31:0] w;
    ready = 1'b1;
    ctrl(8'd1);
    write_hdr(s);
    rx_q.delete(); exp_q.delete();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          w = $urandom; push_exp(w, 8, 1'b0); wr(w, s);
        end
        ctrl(8'd0);
        done = 1'b1;
      end
      begin
        int n;
        n = 0;
        while ((!done || loading) && n < 3000) begin
          @(posedge wclk); #1;
          ready = 1'($urandom_range(0, 1));
          n++;
        end
      end
    join
    ready = 1'b1;
    repeat (3) cyc();
    if (loading !== 1'b0) begin errors++; $display("FAIL b2b_finished: got loading=%b required 0", loading); end
    checks++;
    if (rx_q.size() !== 48) begin errors++; $display("FAIL b2b_total: got %0d slices required 48", rx_q.size()); end
    checks++;
    for (int i = 0; i < 48 && i < rx_q.size(); i++) begin
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_slice%0d: got %h required %h", i, rx_q[i], exp_q[i]); end
      checks++;
    end
    if (count !== 24'd48) begin errors++; $display("FAIL b2b_count: got %0d required 48", count); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_msb();
    test_backpressure();
    test_finish_drain();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
